reaction_multi: RTL and testbench

- Multi-round reaction-time tester, the parametrised successor to the single-shot reaction timer.
- Runs ROUNDS trials back-to-back, each with a pseudo-random foreperiod, then reports the average and best times.
- Detects early presses ("false start") and no-response timeouts.
- Sits between debounced button pulses and the binary-to-BCD/LED-mux display path.

---
 rtl/reaction_pkg.sv | 29 ++
 rtl/reaction_lfsr.sv | 37 +++
 rtl/reaction_multi.sv | 193 +++++++++++++++++++
 tb/tb_reaction_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the multi-round reaction tester.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    REACT   = 3'd3,
    REC     = 3'd4,
    RESULT  = 3'd5,
    SUMMARY = 3'd6,
    FAULT   = 3'd7
  } t_state;

  typedef enum logic [1:0] {
    DISP_HI  = 2'd0,
    DISP_VAL = 2'd1,
    DISP_ERR = 2'd2
  } t_disp_mode;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          TIME_W    = 14;

  // Right-shifting Galois step: feedback bit is the outgoing LSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit LFSR with a rejection-sampled foreperiod draw.
module reaction_lfsr
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          LOWER = 2_000,
  parameter int          UPPER = 15_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_valid,
  output logic [TIME_W-1:0]   o_val
);

  localparam int SPAN = UPPER - LOWER + 1;
  localparam int W    = $clog2(SPAN);
  localparam logic [W:0]        SPAN_V  = SPAN[W:0];
  localparam logic [TIME_W-1:0] LOWER_V = TIME_W'(LOWER);

  logic [15:0]  lfsr_r;
  logic [W-1:0] low_s;

  // Sequence advances every cycle regardless of FSM state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_r <= SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Low bits outside the span are rejected so the draw stays uniform.
  assign low_s   = lfsr_r[W-1:0];
  assign o_valid = ({1'b0, low_s} < SPAN_V);
  assign o_val   = LOWER_V + TIME_W'(low_s);

endmodule

// File: rtl/reaction_multi.sv
// Multi-round reaction-time tester: random foreperiod, false-start and
// timeout detection, per-session average and best time.
module reaction_multi
  import reaction_pkg::*;
#(
  parameter int          CLK_FREQ_HZ   = 100_000_000,
  parameter int          TICK_HZ       = 1_000,
  parameter int          ROUNDS        = 4,
  parameter int          LOWER_WAIT_MS = 2_000,
  parameter int          UPPER_WAIT_MS = 15_000,
  parameter int          MAX_REACT_MS  = 9_999,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_clear,
  output logic [13:0]                   o_display_val,
  output logic [1:0]                    o_display_mode,
  output logic                          o_led,
  output logic [$clog2(ROUNDS+1)-1:0]   o_round,
  output logic [13:0]                   o_best,
  output logic                          o_done
);

  localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW    = $clog2(DIV);
  localparam int RW    = $clog2(ROUNDS + 1);
  localparam int LOG_R = $clog2(ROUNDS);
  localparam int SW    = TIME_W + LOG_R;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [TIME_W-1:0] MAX_T      = TIME_W'(MAX_REACT_MS);
  localparam logic [RW-1:0]     ROUNDS_V   = RW'(ROUNDS);

  t_state              state_r;
  logic [PW-1:0]       presc_r;
  logic [TIME_W-1:0]   wait_r;
  logic [TIME_W-1:0]   react_r;
  logic [TIME_W-1:0]   last_r;
  logic [TIME_W-1:0]   best_r;
  logic [SW-1:0]       sum_r;
  logic [RW-1:0]       round_r;

  logic                tick_s;
  logic [PW-1:0]       presc_next_s;
  logic                draw_valid_s;
  logic [TIME_W-1:0]   draw_val_s;
  logic [TIME_W-1:0]   avg_s;

  reaction_lfsr #(
    .SEED  (SEED),
    .LOWER (LOWER_WAIT_MS),
    .UPPER (UPPER_WAIT_MS)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_valid (draw_valid_s),
    .o_val   (draw_val_s)
  );

  assign tick_s       = (presc_r == PRESC_LAST);
  assign presc_next_s = tick_s ? '0 : presc_r + PW'(1);
  assign avg_s        = TIME_W'(sum_r >> LOG_R);

  // Session FSM with prescaler, counters and statistics.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      presc_r <= '0;
      wait_r  <= '0;
      react_r <= '0;
      last_r  <= '0;
      best_r  <= '0;
      sum_r   <= '0;
      round_r <= '0;
    end else if (i_clear) begin
      state_r <= IDLE;
      presc_r <= presc_next_s;
      last_r  <= '0;
      best_r  <= '0;
      sum_r   <= '0;
      round_r <= '0;
    end else begin
      presc_r <= presc_next_s;
      case (state_r)
        IDLE: begin
          if (i_start) state_r <= ARM;
        end
        ARM: begin
          if (draw_valid_s) begin
            wait_r  <= draw_val_s;
            presc_r <= '0;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (i_stop) begin
            state_r <= FAULT;
          end else if (tick_s) begin
            if (wait_r <= 14'd1) begin
              react_r <= '0;
              presc_r <= '0;
              state_r <= REACT;
            end else begin
              wait_r <= wait_r - 14'd1;
            end
          end
        end
        REACT: begin
          // A stop on a tick cycle records the count before that tick.
          if (i_stop) begin
            last_r  <= react_r;
            state_r <= REC;
          end else if (tick_s) begin
            if (react_r >= MAX_T - 14'd1) begin
              react_r <= MAX_T;
              last_r  <= MAX_T;
              state_r <= REC;
            end else begin
              react_r <= react_r + 14'd1;
            end
          end
        end
        REC: begin
          sum_r   <= sum_r + SW'(last_r);
          round_r <= round_r + RW'(1);
          if ((round_r == '0) || (last_r < best_r)) begin
            best_r <= last_r;
          end
          if (round_r + RW'(1) == ROUNDS_V) begin
            state_r <= SUMMARY;
          end else begin
            state_r <= RESULT;
          end
        end
        RESULT: begin
          if (i_start) state_r <= ARM;
        end
        SUMMARY: begin
          if (i_start) begin
            last_r  <= '0;
            best_r  <= '0;
            sum_r   <= '0;
            round_r <= '0;
            state_r <= ARM;
          end
        end
        FAULT: begin
          if (i_start) state_r <= ARM;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Display/LED decode from registered state only.
  always_comb begin
    o_display_mode = DISP_HI;
    o_display_val  = '0;
    o_led          = 1'b0;
    o_done         = 1'b0;
    case (state_r)
      WAIT, REC, RESULT: begin
        o_display_mode = DISP_VAL;
        o_display_val  = last_r;
      end
      REACT: begin
        o_display_mode = DISP_VAL;
        o_display_val  = react_r;
        o_led          = 1'b1;
      end
      SUMMARY: begin
        o_display_mode = DISP_VAL;
        o_display_val  = avg_s;
        o_done         = 1'b1;
      end
      FAULT: begin
        o_display_mode = DISP_ERR;
      end
      default: begin
        o_display_mode = DISP_HI;
      end
    endcase
  end

  assign o_round = round_r;
  assign o_best  = best_r;

endmodule

// File: tb/tb_reaction_multi.sv
// Randomized self-checking bench for reaction_multi against a session-level model.
module tb_reaction_multi;

  localparam int CLK_HZ  = 10_000;
  localparam int TICK_HZ = 1_000;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int ROUNDS  = 4;
  localparam int LOWER   = 2;
  localparam int UPPER   = 5;
  localparam int MAXR    = 20;
  localparam int SPAN    = UPPER - LOWER + 1;
  localparam int MASK    = (1 << $clog2(SPAN)) - 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic [13:0] val;
  logic [1:0]  mode;
  logic        led;
  logic [2:0]  rnd;
  logic [13:0] best;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc;
  int q[$];
  int n0;

  reaction_multi #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .TICK_HZ       (TICK_HZ),
    .ROUNDS        (ROUNDS),
    .LOWER_WAIT_MS (LOWER),
    .UPPER_WAIT_MS (UPPER),
    .MAX_REACT_MS  (MAXR),
    .SEED          (SEED)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .i_clear        (clear),
    .o_display_val  (val),
    .o_display_mode (mode),
    .o_led          (led),
    .o_round        (rnd),
    .o_best         (best),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: position in the pseudo-random stream.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int lfsr_after(input int n);
    int x;
    x = int'(SEED);
    for (int i = 0; i < n; i++) begin
      if (x % 2 == 1) x = (x / 2) ^ 32'h0000B400;
      else            x = x / 2;
    end
    return x;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic begin_round();
    if (q.size() == ROUNDS) q.delete();
    drive(1'b1, 1'b0, 1'b0);
  endtask

  // From ARM: expect the LED after the predicted foreperiod.
  task automatic run_arm(output int n);
    int r, w, last;
    r = 0;
    while ((lfsr_after(cyc + r) & MASK) >= SPAN) r++;
    w = LOWER + (lfsr_after(cyc + r) & MASK);
    last = (q.size() == 0) ? 0 : q[$];
    n = 0;
    while (!led && n < 1 + r + UPPER * DIV + 5) begin
      @(negedge clk);
      n++;
      if (n == 1 + r) begin
        check("wait_mode", int'(mode), 1);
        check("wait_val", int'(val), last);
      end
    end
    check("wait_len", n, 1 + r + w * DIV);
    check("wait_range", int'((n - 1 - r) >= LOWER * DIV && (n - 1 - r) <= UPPER * DIV), 1);
  endtask

  task automatic check_rec(input int t);
    int s, m;
    q.push_back(t);
    @(negedge clk);
    s = 0;
    m = q[0];
    foreach (q[i]) begin
      s += q[i];
      if (q[i] < m) m = q[i];
    end
    check("round", int'(rnd), q.size());
    check("best", int'(best), m);
    check("res_mode", int'(mode), 1);
    if (q.size() == ROUNDS) begin
      check("done", int'(done), 1);
      check("avg", int'(val), s / ROUNDS);
    end else begin
      check("done", int'(done), 0);
      check("result_val", int'(val), t);
    end
  endtask

  // Stop lands on the edge t*DIV+c after REACT entry.
  task automatic react_stop(input int t, input int c, input logic both);
    int k;
    k = t * DIV + c - 1;
    repeat (k) @(negedge clk);
    check("live_val", int'(val), k / DIV);
    drive(both, 1'b1, 1'b0);
    check_rec(k / DIV);
  endtask

  task automatic react_timeout();
    int n;
    n = 0;
    while (led && n < MAXR * DIV + 5) begin
      @(negedge clk);
      n++;
    end
    check("timeout_len", n, MAXR * DIV);
    check_rec(MAXR);
  endtask

  task automatic fault_round();
    int k;
    begin_round();
    k = $urandom_range(1, 2 * DIV);
    repeat (k) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0);
    check("fault_mode", int'(mode), 2);
    check("fault_led", int'(led), 0);
    check("fault_round", int'(rnd), q.size());
  endtask

  initial begin
    int n, t, c;
    logic both;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mode", int'(mode), 0);
    check("rst_val", int'(val), 0);
    check("rst_led", int'(led), 0);
    check("rst_round", int'(rnd), 0);
    check("rst_best", int'(best), 0);
    check("rst_done", int'(done), 0);

    // Session with times 3, 7, 2, 8 and a false start before round 2.
    begin_round(); run_arm(n0); react_stop(3, 4, 1'b0);
    fault_round();
    begin_round(); run_arm(n); react_stop(7, 4, 1'b0);
    begin_round(); run_arm(n); react_stop(2, 4, 1'b0);
    begin_round(); run_arm(n); react_stop(8, 4, 1'b0);

    drive(1'b0, 1'b0, 1'b1);
    q.delete();
    check("clr_mode", int'(mode), 0);
    check("clr_done", int'(done), 0);
    check("clr_best", int'(best), 0);
    check("clr_round", int'(rnd), 0);

    for (int r = 0; r < ROUNDS; r++) begin
      begin_round(); run_arm(n); react_timeout();
    end

    for (int s = 0; s < 3; s++) begin
      for (int r = 0; r < ROUNDS; r++) begin
        if ($urandom_range(0, 3) == 0) fault_round();
        begin_round();
        run_arm(n);
        if ($urandom_range(0, 7) == 0) begin
          react_timeout();
        end else begin
          t = $urandom_range(0, MAXR - 1);
          c = $urandom_range(0, DIV);
          if (t == 0 && c == 0) c = 1;
          both = (s == 0 && r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          react_stop(t, c, both);
        end
      end
    end

    // Reset in the middle of round 2 of a fresh session.
    begin_round(); run_arm(n); react_stop(1, 5, 1'b0);
    begin_round(); run_arm(n);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_round", int'(rnd), 0);
    check("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    begin_round(); run_arm(n);
    check("seed_restart", n, n0);
    react_stop(2, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
